solver_sequencer: RTL and testbench
===================================

SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

Interface
REQ-001 Parameters: N=4 (matrix dimension); W=16 (element width, signed fixed point); TIMEOUT=1024 (max SOLVE cycles).
REQ-002 clk_100mhz  in  1  sole clock; all logic is rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  covariance element valid.
REQ-005 in_data  in  W  covariance element, row-major order, element 0 = cov[0][0].
REQ-006 in_ready  out  1  sequencer accepts in_data.
REQ-007 slv_valid  out  1  launch request to the solver.
REQ-008 slv_cov  out  N x N x W  matrix presented to the solver.
REQ-009 slv_reset  out  1  one-cycle solver clear.
REQ-010 slv_x  in  N x W  solver result vector.
REQ-011 slv_ready  in  1  solver result valid.
REQ-012 out_valid  out  1  result available.
REQ-013 out_x  out  N x W  captured result.
REQ-014 out_timeout  out  1  qualifies out_valid: result is a timeout, not a solve.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 busy  out  1  state != IDLE.
REQ-017 err_count  out  8  timeout count, saturating at 255.

Function
REQ-018 States: IDLE, LOAD, SOLVE, OUTPUT, RECOVER.
REQ-019 in_ready = 1 only in IDLE and LOAD; an element is accepted when in_valid & in_ready.
REQ-020 Accepted element k (k = 0..15) is written to matrix[k/4][k%4]; the 4-bit element counter increments once per accept.
REQ-021 IDLE -> LOAD on the first accept (counter becomes 1); LOAD -> SOLVE on the accept with counter = 15; counter then wraps to 0.
REQ-022 slv_valid = 1 throughout SOLVE, starting the cycle after the last element is accepted; 0 in all other states.
REQ-023 slv_cov is driven directly from the matrix register and is stable throughout SOLVE.
REQ-024 In SOLVE, the first cycle with slv_ready = 1 latches slv_x into out_x, sets out_timeout = 0 and moves to OUTPUT; out_valid rises the following cycle.
REQ-025 A SOLVE cycle counter starts at 0 on SOLVE entry; if slv_ready is still 0 when the counter = TIMEOUT-1, the next state is RECOVER.
REQ-026 If slv_ready and the timeout occur in the same cycle, slv_ready takes priority.
REQ-027 RECOVER lasts exactly one cycle: slv_reset = 1, out_x = 0, out_timeout = 1, err_count += 1 (saturating), then OUTPUT.
REQ-028 OUTPUT: out_valid = 1; out_x and out_timeout are held stable until out_valid & out_ready.
REQ-029 OUTPUT -> IDLE on out_valid & out_ready; in_ready rises the following cycle.
REQ-030 slv_ready outside SOLVE is ignored; in_valid outside IDLE/LOAD is not accepted and causes no state change.
REQ-031 slv_valid is low for at least one cycle between consecutive launches.

Reset
REQ-032 While reset = 1: state = IDLE, counters = 0, matrix = 0, out_x = 0, out_valid = 0, out_timeout = 0, slv_valid = 0, slv_reset = 0, err_count = 0, busy = 0.
REQ-033 A reset asserted in any state, including mid-LOAD or mid-SOLVE, discards the partial matrix and any pending result; no result is emitted.
REQ-034 in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-035 N, W, TIMEOUT, the state enum, and the matrix/vector typedefs live in shared package solver_pkg.
REQ-036 No sub-module; linear_solver is instantiated beside this block at the next level up, not inside it.

Verification
REQ-037 Identity load: diagonal elements 16'h2000, all others 0; stub solver asserts slv_ready 20 cycles after slv_valid with x = {1,2,3,4} -> out_valid with out_x = {1,2,3,4}, out_timeout = 0; slv_valid asserted exactly 1 cycle after the 16th accept.
REQ-038 Backpressure: in_valid toggles every other cycle during load, and out_ready is held 0 for 10 cycles -> matrix matches the input order; out_x is stable while stalled; in_ready stays low until 1 cycle after acceptance.
REQ-039 Timeout: stub never responds -> after 1024 SOLVE cycles, slv_reset pulses once, out_timeout = 1, out_x = 0, err_count = 1; the next job completes normally.
REQ-040 Tie: slv_ready first asserted on SOLVE cycle 1023 -> normal result; err_count unchanged.
REQ-041 Reset after 7 elements loaded: assert reset, then load a full new matrix -> slv_cov contains only new-matrix values; no out_valid is produced for the aborted job.
REQ-042 Saturation: 260 forced timeouts -> err_count = 255.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared dimensions, element/matrix/vector types and FSM states for the
// covariance-solver sequencer and its neighbouring linear_solver.
package solver_pkg;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 1024;

  typedef logic signed [W-1:0]  elem_t;
  typedef elem_t [N-1:0]        vector_t;
  typedef elem_t [N-1:0][N-1:0] matrix_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SOLVE,
    OUTPUT,
    RECOVER
  } state_t;

endpackage

// File: rtl/solver_sequencer.sv
// Collects an N x N covariance matrix element by element, launches the external
// solver, and hands back its result or a timeout indication with an error count.
module solver_sequencer
  import solver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = solver_pkg::TIMEOUT
) (
  input  logic          clk_100mhz,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          slv_valid,
  output matrix_t       slv_cov,
  output logic          slv_reset,
  input  vector_t       slv_x,
  input  logic          slv_ready,
  output logic          out_valid,
  output vector_t       out_x,
  output logic          out_timeout,
  input  logic          out_ready,
  output logic          busy,
  output logic [7:0]    err_count
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2*IW-1:0] LAST_ELEM  = (2*IW)'(N*N - 1);
  localparam logic [TW-1:0]   LAST_SOLVE = TW'(TIMEOUT_CYCLES - 1);

  state_t           state;
  matrix_t          matrix;
  logic [2*IW-1:0]  elem_cnt;
  logic [TW-1:0]    solve_cnt;

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);
  assign slv_cov  = matrix;

  // Element counter's upper bits select the row, lower bits the column, so
  // the row-major stream lands directly in place.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state       <= IDLE;
      matrix      <= '0;
      elem_cnt    <= '0;
      solve_cnt   <= '0;
      slv_valid   <= 1'b0;
      slv_reset   <= 1'b0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            matrix[elem_cnt[2*IW-1:IW]][elem_cnt[IW-1:0]] <= in_data;
            elem_cnt <= elem_cnt + 1'b1;
            if (elem_cnt == LAST_ELEM) begin
              state     <= SOLVE;
              slv_valid <= 1'b1;
              solve_cnt <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end

        // A response on the final budget cycle still counts as a solve.
        SOLVE: begin
          if (slv_ready) begin
            out_x       <= slv_x;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            slv_valid   <= 1'b0;
            state       <= OUTPUT;
          end else if (solve_cnt == LAST_SOLVE) begin
            out_x       <= '0;
            out_timeout <= 1'b1;
            slv_valid   <= 1'b0;
            slv_reset   <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            state <= RECOVER;
          end else begin
            solve_cnt <= solve_cnt + 1'b1;
          end
        end

        RECOVER: begin
          slv_reset <= 1'b0;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end

        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_sequencer.sv
// Randomized self-checking bench for solver_sequencer: a stub solver with
// programmable response delay and a job-level reference model of the results.
module tb_solver_sequencer;
  import solver_pkg::*;

  localparam int CW     = N * N * W;
  localparam int SAT_TO = 16;
  typedef logic [CW-1:0] cmp_t;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic         reset, in_valid, in_ready, slv_valid, slv_reset, slv_ready;
  logic         out_valid, out_timeout, out_ready, busy;
  logic [W-1:0] in_data;
  logic [7:0]   err_count;
  matrix_t      slv_cov;
  vector_t      slv_x, out_x;

  logic         b_reset, b_in_valid, b_in_ready, b_slv_valid, b_slv_reset, b_slv_ready;
  logic         b_out_valid, b_out_timeout, b_out_ready, b_busy;
  logic [W-1:0] b_in_data;
  logic [7:0]   b_err_count;
  matrix_t      b_slv_cov;
  vector_t      b_slv_x, b_out_x;

  solver_sequencer dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .slv_valid(slv_valid), .slv_cov(slv_cov), .slv_reset(slv_reset),
    .slv_x(slv_x), .slv_ready(slv_ready), .out_valid(out_valid), .out_x(out_x),
    .out_timeout(out_timeout), .out_ready(out_ready), .busy(busy), .err_count(err_count)
  );

  // Short timeout so hundreds of forced timeouts fit in a brief run.
  solver_sequencer #(.TIMEOUT_CYCLES(SAT_TO)) dut_sat (
    .clk_100mhz(clk_100mhz), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .slv_valid(b_slv_valid), .slv_cov(b_slv_cov), .slv_reset(b_slv_reset),
    .slv_x(b_slv_x), .slv_ready(b_slv_ready), .out_valid(b_out_valid), .out_x(b_out_x),
    .out_timeout(b_out_timeout), .out_ready(b_out_ready), .busy(b_busy), .err_count(b_err_count)
  );

  int           vectors = 0;
  int           miscompares = 0;
  int           exp_err = 0;
  logic [W-1:0] elems [N*N];
  vector_t      xexp;

  task automatic checkOutput(input string tag, input cmp_t got, input cmp_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmp_t expMatrix();
    cmp_t flat = '0;
    for (int k = 0; k < N*N; k++) begin
      flat = flat | (cmp_t'(elems[k]) << (k * W));
    end
    return flat;
  endfunction

  task automatic randomElems();
    for (int k = 0; k < N*N; k++) elems[k] = W'($urandom);
    xexp = {$urandom, $urandom};
  endtask

  // Streams n elements; with toggle set, every other cycle carries a bubble.
  task automatic loadMatrix(input int n, input bit toggle);
    int k = 0;
    int cyc = 0;
    while (k < n) begin
      @(negedge clk_100mhz);
      checkOutput("load_in_ready", cmp_t'(in_ready), cmp_t'(1));
      checkOutput("load_slv_valid", cmp_t'(slv_valid), cmp_t'(0));
      slv_ready = 1'($urandom_range(0, 1));
      slv_x     = {$urandom, $urandom};
      if (toggle && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = elems[k];
        k++;
      end
      cyc++;
    end
    @(negedge clk_100mhz);
    in_valid  = 1'b0;
    slv_ready = 1'b0;
    if (n == N*N) begin
      checkOutput("launch_slv_valid", cmp_t'(slv_valid), cmp_t'(1));
      checkOutput("launch_in_ready", cmp_t'(in_ready), cmp_t'(0));
      checkOutput("launch_busy", cmp_t'(busy), cmp_t'(1));
      checkOutput("launch_cov", cmp_t'(slv_cov), expMatrix());
    end
  endtask

  // ready_at: SOLVE cycle on which the stub answers (-1 = never).
  task automatic solveAndDrain(input int ready_at, input int stall);
    bit      got = 1'b0;
    vector_t exp_res;
    bit      exp_to;
    for (int c = 0; c < TIMEOUT && !got; c++) begin
      if (c > 0) @(negedge clk_100mhz);
      checkOutput("solve_slv_valid", cmp_t'(slv_valid), cmp_t'(1));
      checkOutput("solve_cov", cmp_t'(slv_cov), expMatrix());
      checkOutput("solve_out_valid", cmp_t'(out_valid), cmp_t'(0));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      slv_ready = (c == ready_at);
      slv_x     = slv_ready ? xexp : vector_t'({$urandom, $urandom});
      got       = slv_ready;
    end
    @(negedge clk_100mhz);
    slv_ready = 1'($urandom_range(0, 1));
    slv_x     = {$urandom, $urandom};
    if (!got) begin
      if (exp_err < 255) exp_err++;
      checkOutput("recover_slv_reset", cmp_t'(slv_reset), cmp_t'(1));
      checkOutput("recover_timeout", cmp_t'(out_timeout), cmp_t'(1));
      checkOutput("recover_out_x", cmp_t'(out_x), cmp_t'(0));
      checkOutput("recover_err", cmp_t'(err_count), cmp_t'(exp_err));
      checkOutput("recover_out_valid", cmp_t'(out_valid), cmp_t'(0));
      checkOutput("recover_slv_valid", cmp_t'(slv_valid), cmp_t'(0));
      @(negedge clk_100mhz);
      slv_ready = 1'($urandom_range(0, 1));
      exp_res = '0;
      exp_to  = 1'b1;
    end else begin
      exp_res = xexp;
      exp_to  = 1'b0;
    end
    checkOutput("output_slv_reset", cmp_t'(slv_reset), cmp_t'(0));
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk_100mhz);
      checkOutput("output_valid", cmp_t'(out_valid), cmp_t'(1));
      checkOutput("output_x", cmp_t'(out_x), cmp_t'(exp_res));
      checkOutput("output_timeout", cmp_t'(out_timeout), cmp_t'(exp_to));
      checkOutput("output_err", cmp_t'(err_count), cmp_t'(exp_err));
      checkOutput("output_slv_valid", cmp_t'(slv_valid), cmp_t'(0));
      checkOutput("output_in_ready", cmp_t'(in_ready), cmp_t'(0));
      out_ready = (s == stall);
      in_valid  = 1'($urandom_range(0, 1));
      slv_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk_100mhz);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    slv_ready = 1'b0;
    checkOutput("idle_in_ready", cmp_t'(in_ready), cmp_t'(1));
    checkOutput("idle_out_valid", cmp_t'(out_valid), cmp_t'(0));
    checkOutput("idle_busy", cmp_t'(busy), cmp_t'(0));
  endtask

  task automatic applyStimulus(input bit toggle, input int ready_at, input int stall);
    loadMatrix(N*N, toggle);
    solveAndDrain(ready_at, stall);
  endtask

  task automatic checkAbort(input string tag);
    @(negedge clk_100mhz);
    checkOutput({tag, "_out_valid"}, cmp_t'(out_valid), cmp_t'(0));
    checkOutput({tag, "_busy"}, cmp_t'(busy), cmp_t'(0));
    checkOutput({tag, "_slv_valid"}, cmp_t'(slv_valid), cmp_t'(0));
    checkOutput({tag, "_cov"}, cmp_t'(slv_cov), cmp_t'(0));
    checkOutput({tag, "_err"}, cmp_t'(err_count), cmp_t'(0));
    reset   = 1'b0;
    exp_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100mhz);
      checkOutput({tag, "_no_result"}, cmp_t'(out_valid), cmp_t'(0));
      checkOutput({tag, "_in_ready"}, cmp_t'(in_ready), cmp_t'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; slv_x = '0; slv_ready = 1'b0; out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b1; b_in_data = '0; b_slv_x = '0; b_slv_ready = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    checkOutput("reset_out_valid", cmp_t'(out_valid), cmp_t'(0));
    checkOutput("reset_busy", cmp_t'(busy), cmp_t'(0));
    checkOutput("reset_slv_valid", cmp_t'(slv_valid), cmp_t'(0));
    checkOutput("reset_slv_reset", cmp_t'(slv_reset), cmp_t'(0));
    checkOutput("reset_out_x", cmp_t'(out_x), cmp_t'(0));
    checkOutput("reset_timeout", cmp_t'(out_timeout), cmp_t'(0));
    checkOutput("reset_cov", cmp_t'(slv_cov), cmp_t'(0));
    checkOutput("reset_err", cmp_t'(err_count), cmp_t'(0));
    reset = 1'b0;
    @(negedge clk_100mhz);
    checkOutput("post_reset_in_ready", cmp_t'(in_ready), cmp_t'(1));

    // Identity matrix, solver answers after 20 cycles with {1,2,3,4}.
    for (int k = 0; k < N*N; k++) elems[k] = (k / N == k % N) ? 16'h2000 : 16'h0000;
    xexp = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    applyStimulus(1'b0, 20, 0);

    randomElems();
    applyStimulus(1'b1, 7, 10);

    randomElems();
    applyStimulus(1'b0, -1, 2);
    randomElems();
    applyStimulus(1'b0, 5, 0);

    randomElems();
    applyStimulus(1'b0, TIMEOUT - 1, 1);

    repeat (6) begin
      randomElems();
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 60), $urandom_range(0, 4));
    end

    // Abort mid-load, then a fresh matrix must contain only new values.
    randomElems();
    loadMatrix(7, 1'b0);
    reset = 1'b1;
    checkAbort("abort_load");
    randomElems();
    applyStimulus(1'b0, 3, 0);

    // Abort mid-solve.
    randomElems();
    loadMatrix(N*N, 1'b0);
    repeat (4) @(negedge clk_100mhz);
    reset = 1'b1;
    checkAbort("abort_solve");
    randomElems();
    applyStimulus(1'b0, 9, 1);

    // Saturation: the short-timeout instance reloads and times out repeatedly.
    @(negedge clk_100mhz);
    b_reset = 1'b0;
    for (int j = 0; j < 260; j++) begin
      waited = 0;
      do begin
        @(negedge clk_100mhz);
        b_in_data = W'($urandom);
        waited++;
      end while (!b_slv_reset && waited < 100);
      checkOutput("sat_recover_seen", cmp_t'(b_slv_reset), cmp_t'(1));
      if (!b_slv_reset) break;
      checkOutput("sat_err", cmp_t'(b_err_count), cmp_t'((j + 1 > 255) ? 255 : j + 1));
    end
    checkOutput("sat_final_err", cmp_t'(b_err_count), cmp_t'(255));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
